// File: rtl/ysyx_22040127_idu_if.sv
// Fetch-to-decode and decode-to-execute channels of the instruction-decode stage.
// The master drives the fetch side and consumes decoded entries; the slave is the decoder.
interface ysyx_22040127_idu_if #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 16
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_inst;
  logic [XLEN-1:0]  in_pc;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_pc;
  logic [4:0]       out_rd;
  logic [4:0]       out_rs1;
  logic [4:0]       out_rs2;
  logic [2:0]       out_type;
  logic [XLEN-1:0]  out_imm;
  logic [2:0]       out_funct3;
  logic             out_reg_wen;
  logic             out_memread;
  logic             out_memwrite;
  logic             out_word;
  logic             out_illegal;
  logic [CNT_W-1:0] illegal_cnt;

  modport master (
    output flush, in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_type, out_imm,
           out_funct3, out_reg_wen, out_memread, out_memwrite, out_word, out_illegal,
           illegal_cnt
  );

  modport slave (
    input  flush, in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_type, out_imm,
           out_funct3, out_reg_wen, out_memread, out_memwrite, out_word, out_illegal,
           illegal_cnt
  );
endinterface

// File: rtl/ysyx_22040127_idu.sv
// Registered RV32/RV64(+M) instruction decoder with valid/ready output register,
// flush, and a saturating illegal-instruction counter.
module ysyx_22040127_idu #(
  parameter int XLEN  = 64,
  parameter bit M_EXT = 1'b1,
  parameter int CNT_W = 16
) (
  input logic                  clk,
  input logic                  rst,
  ysyx_22040127_idu_if.slave   io
);
  typedef enum logic [2:0] {
    TYPE_I       = 3'd0,
    TYPE_U       = 3'd1,
    TYPE_S       = 3'd2,
    TYPE_J       = 3'd3,
    TYPE_R       = 3'd4,
    TYPE_B       = 3'd5,
    TYPE_N       = 3'd6,
    TYPE_ILLEGAL = 3'd7
  } inst_type_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_OP32   = 7'b0111011;

  logic [31:0]     inst;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  inst_type_e      type_d;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm_d;
  logic            reg_wen_d;
  logic            memread_d;
  logic            memwrite_d;
  logic            word_d;
  logic            capture;

  assign inst   = io.in_inst;
  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];

  always_comb begin
    type_d = TYPE_ILLEGAL;
    case (opcode)
      7'b0010111, 7'b0110111:                         type_d = TYPE_U;
      7'b0010011, OP_LOAD, 7'b1100111, OP_IMM32:      type_d = TYPE_I;
      7'b1101111:                                     type_d = TYPE_J;
      7'b0110011, OP_OP32:                            type_d = TYPE_R;
      7'b1110011:                                     type_d = TYPE_N;
      OP_STORE:                                       type_d = TYPE_S;
      7'b1100011:                                     type_d = TYPE_B;
      default:                                        type_d = TYPE_ILLEGAL;
    endcase
    // RV64-only encodings: W ops, LD/LWU, SD
    if (XLEN == 32 && (opcode == OP_IMM32 || opcode == OP_OP32 ||
        (opcode == OP_LOAD && (funct3 == 3'b011 || funct3 == 3'b110)) ||
        (opcode == OP_STORE && funct3 == 3'b011)))
      type_d = TYPE_ILLEGAL;
    if (!M_EXT && type_d == TYPE_R && funct7 == 7'b0000001)
      type_d = TYPE_ILLEGAL;
  end

  always_comb begin
    imm32 = '0;
    case (type_d)
      TYPE_I, TYPE_N: imm32 = {{20{inst[31]}}, inst[31:20]};
      TYPE_U:         imm32 = {inst[31:12], 12'b0};
      TYPE_S:         imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      TYPE_B:         imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      TYPE_J:         imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default:        imm32 = '0;
    endcase
  end

  assign imm_d      = XLEN'($signed(imm32));
  assign reg_wen_d  = (type_d inside {TYPE_I, TYPE_U, TYPE_J, TYPE_R}) && (inst[11:7] != 5'd0);
  assign memread_d  = (opcode == OP_LOAD)  && (type_d != TYPE_ILLEGAL);
  assign memwrite_d = (opcode == OP_STORE) && (type_d != TYPE_ILLEGAL);
  assign word_d     = (opcode == OP_IMM32) || (opcode == OP_OP32);

  assign io.in_ready = !io.flush && (!io.out_valid || io.out_ready);
  assign capture     = io.in_valid && io.in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      io.out_valid    <= 1'b0;
      io.out_pc       <= '0;
      io.out_rd       <= '0;
      io.out_rs1      <= '0;
      io.out_rs2      <= '0;
      io.out_type     <= '0;
      io.out_imm      <= '0;
      io.out_funct3   <= '0;
      io.out_reg_wen  <= 1'b0;
      io.out_memread  <= 1'b0;
      io.out_memwrite <= 1'b0;
      io.out_word     <= 1'b0;
      io.out_illegal  <= 1'b0;
      io.illegal_cnt  <= '0;
    end else begin
      if (io.flush)         io.out_valid <= 1'b0;
      else if (capture)     io.out_valid <= 1'b1;
      else if (io.out_ready) io.out_valid <= 1'b0;

      if (capture) begin
        io.out_pc       <= io.in_pc;
        io.out_rd       <= inst[11:7];
        io.out_rs1      <= inst[19:15];
        io.out_rs2      <= inst[24:20];
        io.out_type     <= type_d;
        io.out_imm      <= imm_d;
        io.out_funct3   <= funct3;
        io.out_reg_wen  <= reg_wen_d;
        io.out_memread  <= memread_d;
        io.out_memwrite <= memwrite_d;
        io.out_word     <= word_d;
        io.out_illegal  <= (type_d == TYPE_ILLEGAL);
      end

      if (capture && type_d == TYPE_ILLEGAL && io.illegal_cnt != '1)
        io.illegal_cnt <= io.illegal_cnt + CNT_W'(1);
    end
  end
endmodule
